// File: rtl/mul_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_ctrl
// Description : Sequences EX-stage mul/div instructions through the shared
//               iterative unit: magnitude conversion, launch, sign correction,
//               result hold, EX stall request, divide-by-zero and flush drain.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [3:0]  mul_div_op,
    input  logic        mul_div_sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stallreq,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        unit_start,
    output logic        unit_is_div,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic        unit_done,
    input  logic [31:0] unit_hi,
    input  logic [31:0] unit_lo
);

    localparam logic [1:0]  S_IDLE     = 2'd0;
    localparam logic [1:0]  S_BUSY     = 2'd1;
    localparam logic [1:0]  S_DONE     = 2'd2;
    localparam logic [1:0]  S_DRAIN    = 2'd3;
    localparam logic [31:0] C_ALL_ONES = 32'hFFFF_FFFF;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_op;
    logic        r_a_neg;
    logic        r_b_neg;
    logic        r_unit_start;
    logic        r_unit_is_div;
    logic [31:0] r_unit_a;
    logic [31:0] r_unit_b;
    logic [31:0] r_result;
    logic        r_result_valid;

    logic        w_stallreq;
    logic        w_issue;
    logic        w_is_div;
    logic        w_div_zero;
    logic        w_launch;
    logic        w_div0_accept;
    logic        w_complete;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_neg_prod;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_corrected;
    logic        w_unused_stall;

    assign w_issue       = op_valid & (|mul_div_op) & ~flush;
    assign w_is_div      = mul_div_op[2] | mul_div_op[3];
    assign w_div_zero    = w_is_div & (b == 32'd0);
    assign w_launch      = (r_state == S_IDLE) & w_issue & ~w_div_zero;
    assign w_div0_accept = (r_state == S_IDLE) & w_issue & w_div_zero;
    assign w_complete    = (r_state == S_BUSY) & unit_done & ~flush;

    assign w_a_neg = mul_div_sign & a[31];
    assign w_b_neg = mul_div_sign & b[31];
    // 0x80000000 negates to itself, which is already its correct magnitude
    assign w_a_mag = w_a_neg ? (~a + 32'd1) : a;
    assign w_b_mag = w_b_neg ? (~b + 32'd1) : b;

    // Product sign is applied across all 64 bits so the borrow reaches the high half
    assign w_neg_prod = r_a_neg ^ r_b_neg;
    assign w_prod     = {unit_hi, unit_lo};
    assign w_prod_fix = w_neg_prod ? (~w_prod + 64'd1) : w_prod;
    assign w_quot     = w_neg_prod ? (~unit_lo + 32'd1) : unit_lo;
    assign w_rem      = r_a_neg ? (~unit_hi + 32'd1) : unit_hi;

    always_comb begin
        w_corrected = w_rem;
        if (r_op[0]) begin
            w_corrected = w_prod_fix[31:0];
        end else if (r_op[1]) begin
            w_corrected = w_prod_fix[63:32];
        end else if (r_op[2]) begin
            w_corrected = w_quot;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stallreq   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stallreq = w_issue;
                if (w_issue) begin
                    w_state_next = w_div_zero ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                w_stallreq = 1'b1;
                if (flush) begin
                    w_state_next = S_DRAIN;
                end else if (unit_done) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || !stall[2]) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                w_stallreq = op_valid & (|mul_div_op);
                if (unit_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op           <= 4'd0;
            r_a_neg        <= 1'b0;
            r_b_neg        <= 1'b0;
            r_unit_start   <= 1'b0;
            r_unit_is_div  <= 1'b0;
            r_unit_a       <= 32'd0;
            r_unit_b       <= 32'd0;
            r_result       <= 32'd0;
            r_result_valid <= 1'b0;
        end else begin
            r_unit_start <= w_launch;
            if (w_launch) begin
                r_op          <= mul_div_op;
                r_a_neg       <= w_a_neg;
                r_b_neg       <= w_b_neg;
                r_unit_is_div <= w_is_div;
                r_unit_a      <= w_a_mag;
                r_unit_b      <= w_b_mag;
            end
            if (w_div0_accept) begin
                r_result       <= mul_div_op[3] ? a : C_ALL_ONES;
                r_result_valid <= 1'b1;
            end else if (w_complete) begin
                r_result       <= w_corrected;
                r_result_valid <= 1'b1;
            end else if ((r_state == S_DONE) && (w_state_next == S_IDLE)) begin
                r_result_valid <= 1'b0;
            end
        end
    end

    assign stallreq     = reset & w_stallreq;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign unit_start   = r_unit_start;
    assign unit_is_div  = r_unit_is_div;
    assign unit_a       = r_unit_a;
    assign unit_b       = r_unit_b;

    // Only the EX hold bit matters here
    assign w_unused_stall = ^{stall[5:3], stall[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_mul_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_ctrl
// Description : Scoreboard bench for mul_div_ctrl with a behavioural
//               iterative-unit stub and directed hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  stall;
    logic        flush;
    logic        op_valid;
    logic [3:0]  mul_div_op;
    logic        mul_div_sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        stallreq;
    logic [31:0] result;
    logic        result_valid;
    logic        unit_start;
    logic        unit_is_div;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        unit_done;
    logic [31:0] unit_hi;
    logic [31:0] unit_lo;

    localparam logic [3:0] OP_LO  = 4'b0001;
    localparam logic [3:0] OP_HI  = 4'b0010;
    localparam logic [3:0] OP_QUO = 4'b0100;
    localparam logic [3:0] OP_REM = 4'b1000;

    typedef struct {
        logic [31:0] ua;
        logic [31:0] ub;
        logic        is_div;
    } unit_exp_t;

    logic [31:0] res_q[$];
    unit_exp_t   unit_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          unit_lat = 3;

    mul_div_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .op_valid     (op_valid),
        .mul_div_op   (mul_div_op),
        .mul_div_sign (mul_div_sign),
        .a            (a),
        .b            (b),
        .stallreq     (stallreq),
        .result       (result),
        .result_valid (result_valid),
        .unit_start   (unit_start),
        .unit_is_div  (unit_is_div),
        .unit_a       (unit_a),
        .unit_b       (unit_b),
        .unit_done    (unit_done),
        .unit_hi      (unit_hi),
        .unit_lo      (unit_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Iterative unit stand-in: checks launch operands, answers after unit_lat cycles
    initial begin
        logic [31:0] ca;
        logic [31:0] cb;
        logic        cd;
        int          lat;
        logic [63:0] p;
        unit_exp_t   e;
        unit_done = 1'b0;
        unit_hi   = 32'd0;
        unit_lo   = 32'd0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && unit_start === 1'b1) begin
                ca  = unit_a;
                cb  = unit_b;
                cd  = unit_is_div;
                lat = unit_lat;
                if (unit_q.size() == 0) begin
                    fail("unexpected_unit_start");
                end else begin
                    e = unit_q.pop_front();
                    chk("unit_a", 64'(ca), 64'(e.ua));
                    chk("unit_b", 64'(cb), 64'(e.ub));
                    chk("unit_is_div", 64'(cd), 64'(e.is_div));
                end
                repeat (lat) @(posedge clk);
                #1;
                chk("unit_operands_held", {unit_a, unit_b}, {ca, cb});
                chk("unit_is_div_held", 64'(unit_is_div), 64'(cd));
                if (cd) begin
                    unit_lo = (cb == 32'd0) ? 32'hFFFF_FFFF : ca / cb;
                    unit_hi = (cb == 32'd0) ? ca : ca % cb;
                end else begin
                    p       = {32'd0, ca} * {32'd0, cb};
                    unit_hi = p[63:32];
                    unit_lo = p[31:0];
                end
                unit_done = 1'b1;
                @(posedge clk);
                #1;
                unit_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor: compares each newly presented result
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (result_valid === 1'b1 && !prev_valid) begin
                if (res_q.size() == 0) begin
                    fail("unexpected_result");
                end else begin
                    chk("result", 64'(result), 64'(res_q.pop_front()));
                end
            end
            prev_valid = (result_valid === 1'b1);
        end
    end

    task automatic issue(input logic [3:0] op, input logic sgn, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] exp_res, input bit push_res,
                         input bit use_unit, input logic [31:0] ua, input logic [31:0] ub);
        unit_exp_t e;
        @(posedge clk);
        #1;
        op_valid     = 1'b1;
        mul_div_op   = op;
        mul_div_sign = sgn;
        a            = va;
        b            = vb;
        if (push_res) res_q.push_back(exp_res);
        if (use_unit) begin
            e.ua     = ua;
            e.ub     = ub;
            e.is_div = op[2] | op[3];
            unit_q.push_back(e);
        end
    endtask

    task automatic wait_result(input int exp_n);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("stallreq_at_issue", 64'(stallreq), 64'd1);
            if (result_valid === 1'b1) got = 1'b1;
        end
        if (!got) begin
            fail("result_timeout");
        end else begin
            chk("result_latency", 64'(n), 64'(exp_n));
            chk("stallreq_at_result", 64'(stallreq), 64'd0);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic sgn, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] exp_res, input bit use_unit,
                          input logic [31:0] ua, input logic [31:0] ub, input int hold);
        issue(op, sgn, va, vb, exp_res, 1'b1, use_unit, ua, ub);
        wait_result(use_unit ? unit_lat + 3 : 2);
        if (hold > 0) begin
            stall = 6'b000100;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_result", 64'(result), 64'(exp_res));
                chk("hold_valid", 64'(result_valid), 64'd1);
                chk("hold_stallreq", 64'(stallreq), 64'd0);
                chk("hold_no_start", 64'(unit_start), 64'd0);
            end
            stall = 6'b000000;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        stall        = 6'b000000;
        flush        = 1'b0;
        op_valid     = 1'b1;
        mul_div_op   = OP_QUO;
        mul_div_sign = 1'b1;
        a            = 32'h0000_1234;
        b            = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stallreq", 64'(stallreq), 64'd0);
        chk("rst_result_valid", 64'(result_valid), 64'd0);
        chk("rst_unit_start", 64'(unit_start), 64'd0);
        chk("rst_unit_is_div", 64'(unit_is_div), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_unit_ab", {unit_a, unit_b}, 64'd0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        reset    = 1'b1;

        run_op(OP_HI,  1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'h2, 0);
        run_op(OP_LO,  1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 1'b1, 32'h3, 32'h5, 0);
        run_op(OP_HI,  1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 32'h3, 32'h5, 0);
        run_op(OP_QUO, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b1, 32'h7, 32'h2, 0);
        run_op(OP_REM, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 32'h7, 32'h2, 0);
        run_op(OP_QUO, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'h8000_0000, 32'h1, 0);
        run_op(OP_REM, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 32'h1, 0);
        run_op(OP_QUO, 1'b0, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 0);
        run_op(OP_REM, 1'b0, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b0, 32'h0, 32'h0, 0);
        run_op(OP_REM, 1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1'b0, 32'h0, 32'h0, 0);
        run_op(OP_QUO, 1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b1, 32'h64, 32'h7, 0);
        run_op(OP_REM, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 32'h7, 32'h2, 0);
        run_op(OP_QUO, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 32'h7, 32'h2, 0);
        run_op(OP_LO,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h1, 32'h1, 0);
        run_op(OP_HI,  1'b1, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b1, 32'h7, 32'h6, 0);
        run_op(OP_HI,  1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h1, 0);
        run_op(OP_HI,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);

        // Flush two cycles after launch; a new multiply waits behind the drain
        unit_lat = 6;
        issue(OP_LO, 1'b0, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 32'd5, 32'd6);
        @(negedge clk);
        chk("flush_issue_stallreq", 64'(stallreq), 64'd1);
        @(negedge clk);
        chk("flush_unit_start", 64'(unit_start), 64'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush    = 1'b1;
        op_valid = 1'b0;
        issue(OP_LO, 1'b0, 32'd9, 32'd10, 32'h0000_005A, 1'b1, 1'b1, 32'd9, 32'd10);
        flush    = 1'b0;
        unit_lat = 3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_stallreq", 64'(stallreq), 64'd1);
            chk("drain_no_result", 64'(result_valid), 64'd0);
        end
        wait_result(6);

        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("final_result_valid", 64'(result_valid), 64'd0);
        chk("final_stallreq", 64'(stallreq), 64'd0);
        repeat (5) @(negedge clk);
        chk("result_queue_empty", 64'(res_q.size()), 64'd0);
        chk("unit_queue_empty", 64'(unit_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div_ctrl.md
# mul_div_ctrl

Sequencer between the EX stage and the shared iterative multiply/divide unit. It accepts one mul/div instruction at a time, converts signed operands to magnitudes, and launches the unit with a start pulse. On completion it applies sign correction, selects the requested half and holds the result until EX advances. It drives the EX stall request, handles divide-by-zero without using the unit, and discards in-flight operations on flush.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- stall  in  6  pipeline stall vector; stall[2]=1 means EX is held this cycle.
- flush  in  1  kills the instruction in EX; takes priority over everything else except reset.
- op_valid  in  1  EX presents a mul/div instruction.
- mul_div_op  in  4  one-hot opcode:
  - bit0: product low.
  - bit1: product high.
  - bit2: quotient.
  - bit3: remainder.
- mul_div_sign  in  1  1 = signed operands, 0 = unsigned.
- a, b  in  32 each  rs1 and rs2 operands.
- stallreq  out  1  requests a freeze of IF..EX; combinational.
- result  out  32  final corrected value.
- result_valid  out  1  result holds a finished value for the current EX instruction.
- unit_start  out  1  one-cycle launch pulse to the unit.
- unit_is_div  out  1  1 = divide, 0 = multiply; held from start to done.
- unit_a, unit_b  out  32 each  unsigned magnitudes; held from start to done.
- unit_done  in  1  one-cycle pulse; at least 1 cycle after unit_start.
- unit_hi, unit_lo  in  32 each  results, valid when unit_done=1:
  - multiply: {hi,lo} = 64-bit product.
  - divide: hi = remainder, lo = quotient.

## Operation
- States: IDLE, BUSY, DONE, DRAIN.
- issue = op_valid & |mul_div_op & ~flush.
- IDLE, issue, and not (divide with b==0):
  - Latch op, a_neg, b_neg (valid only when mul_div_sign=1) and the operand magnitudes.
  - Magnitude = two's-complement negation when the operand is negative. 0x80000000 stays 0x80000000, which is the correct unsigned value.
  - Go to BUSY. unit_start=1 in the first BUSY cycle only.
- IDLE, issue, divide with b==0:
  - Do not start the unit.
  - Latch result: quotient = 0xFFFFFFFF; remainder = a (unmodified).
  - Go to DONE.
- BUSY, unit_done=1:
  - neg_prod = neg_quot = a_neg ^ b_neg; neg_rem = a_neg.
  - Multiply: negate the full 64-bit {hi,lo} when neg_prod, then select the half.
  - Divide: negate quotient and remainder independently (32-bit).
  - Register the selected value into result, set result_valid, go to DONE.
- DONE:
  - Hold result. stall[2]=1: stay, no re-issue even though op_valid is still high.
  - stall[2]=0: EX advances; clear result_valid, go to IDLE.
- flush:
  - From IDLE or DONE: go to IDLE, clear result_valid.
  - From BUSY, or BUSY with unit_done in the same cycle: go to DRAIN. The result is discarded.
- DRAIN:
  - Wait for unit_done, then go to IDLE. The returning value is discarded.
  - No new issue is accepted until unit_done arrives.
- stallreq = (IDLE & issue) | BUSY | (DRAIN & op_valid & |mul_div_op). Forced 0 while reset=0.
- Signed overflow wraps. Example: -2^31 / -1 gives quotient 0x80000000, remainder 0.

## Timing
- Reset values:
  - state = IDLE.
  - stallreq, result_valid, unit_start, unit_is_div = 0.
  - result, unit_a, unit_b = 0.
- Issue at cycle t: stallreq=1 at t; unit_start=1 with operands valid at t+1.
- unit_done at cycle d: result and result_valid are valid at d+1, and stallreq=0 at d+1.
- Divide by zero issued at t: DONE at t+1 with stallreq=0. One stall cycle in total.
- Back-to-back ops: the second instruction is seen in IDLE one cycle after leaving DONE, with no bubble beyond that.
- unit_a, unit_b, unit_is_div are stable from the unit_start cycle through unit_done.

## Test plan
- Unsigned multiply, a=0xFFFFFFFF, b=2, op=bit1:
  - unit_a=0xFFFFFFFF and unit_b=2.
  - result=0x00000001.
  - stallreq falls in the cycle after unit_done.
- Signed multiply, a=-3, b=5:
  - op=bit0 gives 0xFFFFFFF1.
  - op=bit1 gives 0xFFFFFFFF (64-bit negation carries into the high half).
- Signed divide, a=-7, b=2:
  - unit sees 7 and 2.
  - Quotient gives 0xFFFFFFFD; remainder gives 0xFFFFFFFF.
- Signed divide, a=0x80000000, b=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Divide by zero, a=0x1234, b=0:
  - No unit_start.
  - One stall cycle, then quotient 0xFFFFFFFF and remainder 0x1234.
- Flush two cycles after unit_start, with a new mul op presented next:
  - Stays in DRAIN with stallreq=1 until unit_done; the stale result never appears.
  - The new op's unit_start appears one cycle after entering IDLE.
- DONE with stall[2]=1 for 3 cycles:
  - result is stable, result_valid=1, stallreq=0, no second unit_start.
  - Releasing stall[2] returns to IDLE.
